// File: rtl/timer_io_pkg.sv
// Shared register map, bit positions and reset constants for the timer_io block.
package timer_io_pkg;

   localparam logic [3:0] OFF_CTRL    = 4'h0;
   localparam logic [3:0] OFF_COUNT   = 4'h4;
   localparam logic [3:0] OFF_COMPARE = 4'h8;
   localparam logic [3:0] OFF_STATUS  = 4'hC;

   localparam int CTRL_EN         = 0;
   localparam int CTRL_IRQ_EN     = 1;
   localparam int CTRL_AUTORELOAD = 2;
   localparam int STATUS_MATCH    = 0;

   localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

   // Word-aligned register offset; the low two byte-lane bits never select a register.
   function automatic logic [3:0] reg_off(input logic [3:0] addr);
      return {addr[3:2], 2'b00};
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider producing a one-cycle tick every DIV enabled cycles.
module tick_prescaler #(
   parameter int DIV = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = enable & (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear)       cnt_d = '0;
      else if (enable) cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/timer_io.sv
// Memory-mapped up-counting timer with compare match and level interrupt.
// Optional auto-reload on match is enabled by defining TIMER_IO_AUTORELOAD_EN.
module timer_io
   import timer_io_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 1000000,
   parameter int TICK_HZ     = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

   if (DIV < 1 || DIV * TICK_HZ != CLK_FREQ_HZ) begin : g_div_check
      $error("timer_io: CLK_FREQ_HZ/TICK_HZ must be an integer >= 1");
   end

   logic        ctrl_en_q, ctrl_en_d;
   logic        ctrl_irq_en_q, ctrl_irq_en_d;
   logic        ctrl_ar_q, ctrl_ar_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        match_q, match_d;

   logic wr_ctrl, wr_count, wr_compare, wr_status;
   logic tick, presc_clear, match_evt;
   logic unused_addr;

   assign unused_addr = ^addr[1:0];

   assign wr_ctrl    = we && (reg_off(addr) == OFF_CTRL);
   assign wr_count   = we && (reg_off(addr) == OFF_COUNT);
   assign wr_compare = we && (reg_off(addr) == OFF_COMPARE);
   assign wr_status  = we && (reg_off(addr) == OFF_STATUS);

   // Only an EN 0->1 transition restarts the prescaler phase.
   assign presc_clear = wr_ctrl & wdata[CTRL_EN] & ~ctrl_en_q;

   tick_prescaler #(.DIV(DIV)) u_presc (
      .clk    (clk),
      .reset  (reset),
      .enable (ctrl_en_q),
      .clear  (presc_clear),
      .tick   (tick)
   );

   // A software COUNT load on the tick edge overrides both the increment and the match.
   assign match_evt = tick & ~wr_count & ((count_q + 32'd1) == compare_q);

   always_comb begin
      ctrl_en_d     = ctrl_en_q;
      ctrl_irq_en_d = ctrl_irq_en_q;
      ctrl_ar_d     = ctrl_ar_q;
      count_d       = count_q;
      compare_d     = compare_q;
      match_d       = match_q;

      if (wr_ctrl) begin
         ctrl_en_d     = wdata[CTRL_EN];
         ctrl_irq_en_d = wdata[CTRL_IRQ_EN];
`ifdef TIMER_IO_AUTORELOAD_EN
         ctrl_ar_d     = wdata[CTRL_AUTORELOAD];
`else
         ctrl_ar_d     = 1'b0;
`endif
      end

      if (wr_count)  count_d = wdata;
      else if (tick) count_d = (match_evt && ctrl_ar_q) ? 32'd0 : count_q + 32'd1;

      if (wr_compare) compare_d = wdata;

      if (match_evt)                            match_d = 1'b1;
      else if (wr_status && wdata[STATUS_MATCH]) match_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_en_q     <= 1'b0;
         ctrl_irq_en_q <= 1'b0;
         ctrl_ar_q     <= 1'b0;
         count_q       <= 32'd0;
         compare_q     <= COMPARE_RST;
         match_q       <= 1'b0;
      end else begin
         ctrl_en_q     <= ctrl_en_d;
         ctrl_irq_en_q <= ctrl_irq_en_d;
         ctrl_ar_q     <= ctrl_ar_d;
         count_q       <= count_d;
         compare_q     <= compare_d;
         match_q       <= match_d;
      end
   end

   always_comb begin
      rdata = 32'd0;
      case (reg_off(addr))
         OFF_CTRL: begin
            rdata[CTRL_EN]         = ctrl_en_q;
            rdata[CTRL_IRQ_EN]     = ctrl_irq_en_q;
            rdata[CTRL_AUTORELOAD] = ctrl_ar_q;
         end
         OFF_COUNT:   rdata = count_q;
         OFF_COMPARE: rdata = compare_q;
         OFF_STATUS:  rdata[STATUS_MATCH] = match_q;
         default:     rdata = 32'd0;
      endcase
   end

   assign irq = match_q & ctrl_irq_en_q;

endmodule

// File: tb/tb_timer_io.sv
// Directed bench for timer_io at DIV=1000; expected values are hand-derived cycle counts.
module tb_timer_io;

   localparam logic [3:0] A_CTRL = 4'h0;
   localparam logic [3:0] A_CNT  = 4'h4;
   localparam logic [3:0] A_CMP  = 4'h8;
   localparam logic [3:0] A_STAT = 4'hC;

`ifdef TIMER_IO_AUTORELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  addr = 4'h0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        irq;

   int n_assert = 0;
   int n_fail   = 0;

   timer_io #(.CLK_FREQ_HZ(1000000), .TICK_HZ(1000)) dut (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   // Write takes effect on the next posedge; returns 1ns after that edge.
   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // reset held with a competing write to COMPARE that must be ignored
      reset = 1'b0; we = 1'b1; addr = A_CMP; wdata = 32'h55;
      repeat (3) @(posedge clk);
      #1;
      we = 1'b0; reset = 1'b1;
      rd("rst_ctrl", A_CTRL, 32'h0);
      rd("rst_count", A_CNT, 32'h0);
      rd("rst_compare", A_CMP, 32'hFFFF_FFFF);
      rd("rst_status", A_STAT, 32'h0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      rd("unmapped_byte_off", 4'h6, 32'h0);

      // first tick lands exactly DIV cycles after the enabling write edge
      wr(A_CTRL, 32'h1);
      wait_cyc(999);
      rd("cnt_before_tick", A_CNT, 32'd0);
      wait_cyc(1);
      rd("cnt_first_tick", A_CNT, 32'd1);
      wait_cyc(4000);
      rd("cnt_5000", A_CNT, 32'd5);
      wr(A_CTRL, 32'h0);
      wait_cyc(3000);
      rd("cnt_frozen", A_CNT, 32'd5);
      rd("ctrl_off", A_CTRL, 32'h0);

      // compare match raises MATCH and irq on the edge COUNT becomes 3
      wr(A_CNT, 32'd0);
      wr(A_CMP, 32'd3);
      wr(A_CTRL, 32'h3);
      wait_cyc(2999);
      rd("pre_match_cnt", A_CNT, 32'd2);
      rd("pre_match_stat", A_STAT, 32'd0);
      check("pre_match_irq", {31'd0, irq}, 32'd0);
      wait_cyc(1);
      rd("match_cnt", A_CNT, 32'd3);
      rd("match_stat", A_STAT, 32'd1);
      check("match_irq", {31'd0, irq}, 32'd1);
      wr(A_STAT, 32'h1);
      check("w1c_irq", {31'd0, irq}, 32'd0);
      rd("w1c_stat", A_STAT, 32'd0);
      wr(A_CTRL, 32'h0);

      // 32-bit wrap does not flag a match
      wr(A_CMP, 32'd5);
      wr(A_CNT, 32'hFFFF_FFFE);
      wr(A_CTRL, 32'h1);
      wait_cyc(1000);
      rd("wrap_ffff", A_CNT, 32'hFFFF_FFFF);
      wait_cyc(1000);
      rd("wrap_zero", A_CNT, 32'd0);
      rd("wrap_stat", A_STAT, 32'd0);
      wr(A_CTRL, 32'h0);

      // COUNT load on the tick edge suppresses both increment and match
      wr(A_CNT, 32'd0);
      wr(A_CMP, 32'd1);
      wr(A_CTRL, 32'h1);
      wait_cyc(999);
      wr(A_CNT, 32'h10);
      rd("load_on_tick_cnt", A_CNT, 32'h10);
      rd("load_on_tick_stat", A_STAT, 32'd0);
      wr(A_CMP, 32'h12);
      wait_cyc(1998);
      wr(A_STAT, 32'h1);
      rd("set_wins_cnt", A_CNT, 32'h12);
      rd("set_wins_stat", A_STAT, 32'd1);
      check("irq_gated_off", {31'd0, irq}, 32'd0);
      wr(A_CTRL, 32'h0);

      // auto-reload (or free-run when the feature is compiled out)
      wr(A_STAT, 32'h1);
      wr(A_CNT, 32'd0);
      wr(A_CMP, 32'd4);
      wr(A_CTRL, 32'h7);
      rd("ar_ctrl", A_CTRL, AR ? 32'h7 : 32'h3);
      wait_cyc(3000);
      rd("ar_cnt3", A_CNT, 32'd3);
      wait_cyc(1000);
      rd("ar_cnt4", A_CNT, AR ? 32'd0 : 32'd4);
      rd("ar_stat", A_STAT, 32'd1);
      wait_cyc(1000);
      rd("ar_cnt5", A_CNT, AR ? 32'd1 : 32'd5);

      // reset mid-count with a simultaneous bus write
      wait_cyc(500);
      reset = 1'b0; we = 1'b1; addr = A_CNT; wdata = 32'h77;
      @(posedge clk);
      #1;
      reset = 1'b1; we = 1'b0;
      rd("midrst_cnt", A_CNT, 32'd0);
      rd("midrst_ctrl", A_CTRL, 32'd0);
      rd("midrst_cmp", A_CMP, 32'hFFFF_FFFF);
      rd("midrst_stat", A_STAT, 32'd0);
      check("midrst_irq", {31'd0, irq}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
